// File: rtl/if_stage_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : if_stage_if                                                     |
// | Desc     : Hazard/redirect, instruction-memory and IF/ID signals of the    |
// |            instruction-fetch stage, bundled with master/slave views.       |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
interface if_stage_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 8,
  parameter int CNT_WIDTH  = 16
);
  logic                  stall_IF_ID_i;
  logic                  flush_IF_ID_i;
  logic                  Jump_i;
  logic [ADDR_WIDTH-1:0] jumpAddr_i;
  logic                  PCSrcE_i;
  logic [ADDR_WIDTH-1:0] branchTarget_i;
  logic                  Stop_i;
  logic [ADDR_WIDTH-1:0] instruction_mem_addr_o;
  logic [DATA_WIDTH-1:0] instruction_mem_rD_i;
  logic [ADDR_WIDTH-1:0] PCD_o;
  logic [DATA_WIDTH-1:0] instrD_o;
  logic                  validD_o;
  logic                  halted_o;
  logic [CNT_WIDTH-1:0]  fetch_count_o;

  // The fetch stage is the master: it owns the IM address and the IF/ID outputs.
  modport master (
    input  stall_IF_ID_i, flush_IF_ID_i, Jump_i, jumpAddr_i, PCSrcE_i,
           branchTarget_i, Stop_i, instruction_mem_rD_i,
    output instruction_mem_addr_o, PCD_o, instrD_o, validD_o, halted_o,
           fetch_count_o
  );

  modport slave (
    output stall_IF_ID_i, flush_IF_ID_i, Jump_i, jumpAddr_i, PCSrcE_i,
           branchTarget_i, Stop_i, instruction_mem_rD_i,
    input  instruction_mem_addr_o, PCD_o, instrD_o, validD_o, halted_o,
           fetch_count_o
  );
endinterface
`default_nettype wire

// File: rtl/if_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : if_stage                                                        |
// | Desc     : Instruction-fetch stage: PC, IM address, IF/ID register,        |
// |            branch/jump redirects, stall/flush and Stop drain-and-halt.     |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module if_stage #(
  parameter int                    DATA_WIDTH   = 16,
  parameter int                    ADDR_WIDTH   = 8,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC     = '0,
  parameter logic [DATA_WIDTH-1:0] NOP_INSTR    = 16'h0000,
  parameter int                    DRAIN_CYCLES = 3,
  parameter int                    CNT_WIDTH    = 16
) (
  input  wire       clk,
  input  wire       rst,
  if_stage_if.master bus
);

  localparam int                 c_DCW      = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [c_DCW-1:0]   c_DRAIN_LAST = c_DCW'(DRAIN_CYCLES - 1);
  localparam logic [c_DCW-1:0]   c_DCNT_ONE   = c_DCW'(1);
  localparam logic [ADDR_WIDTH-1:0] c_PC_ONE  = ADDR_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0]  c_CNT_ONE = CNT_WIDTH'(1);

  typedef enum logic [1:0] {
    S_RUN    = 2'd0,
    S_DRAIN  = 2'd1,
    S_HALTED = 2'd2
  } state_t;

  state_t                r_state;
  logic [c_DCW-1:0]      r_drain_cnt;
  logic [ADDR_WIDTH-1:0] r_pc;
  logic [ADDR_WIDTH-1:0] r_pcd;
  logic [DATA_WIDTH-1:0] r_instrd;
  logic                  r_validd;
  logic                  r_halted;
  logic [CNT_WIDTH-1:0]  r_fetch_count;

  logic [ADDR_WIDTH-1:0] w_pc_inc;

  // PC+1 wraps naturally at the address width.
  assign w_pc_inc = r_pc + c_PC_ONE;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_RUN;
      r_drain_cnt   <= '0;
      r_pc          <= RESET_PC;
      r_pcd         <= '0;
      r_instrd      <= NOP_INSTR;
      r_validd      <= 1'b0;
      r_halted      <= 1'b0;
      r_fetch_count <= '0;
    end else begin
      case (r_state)
        S_RUN: begin
          if (bus.PCSrcE_i) begin
            r_pc     <= bus.branchTarget_i;
            r_pcd    <= '0;
            r_instrd <= NOP_INSTR;
            r_validd <= 1'b0;
          end else if (bus.stall_IF_ID_i) begin
            r_pc <= r_pc;
          end else if (bus.Stop_i) begin
            // Accept Stop: freeze PC and let the younger stages drain.
            r_state     <= S_DRAIN;
            r_drain_cnt <= '0;
            r_pcd       <= '0;
            r_instrd    <= NOP_INSTR;
            r_validd    <= 1'b0;
          end else if (bus.Jump_i) begin
            r_pc     <= bus.jumpAddr_i;
            r_pcd    <= '0;
            r_instrd <= NOP_INSTR;
            r_validd <= 1'b0;
          end else if (bus.flush_IF_ID_i) begin
            r_pc     <= w_pc_inc;
            r_pcd    <= '0;
            r_instrd <= NOP_INSTR;
            r_validd <= 1'b0;
          end else begin
            r_pc     <= w_pc_inc;
            r_pcd    <= r_pc;
            r_instrd <= bus.instruction_mem_rD_i;
            r_validd <= 1'b1;
            if (r_fetch_count != {CNT_WIDTH{1'b1}}) begin
              r_fetch_count <= r_fetch_count + c_CNT_ONE;
            end
          end
        end
        S_DRAIN: begin
          r_pcd    <= '0;
          r_instrd <= NOP_INSTR;
          r_validd <= 1'b0;
          if (r_drain_cnt == c_DRAIN_LAST) begin
            r_state  <= S_HALTED;
            r_halted <= 1'b1;
          end else begin
            r_drain_cnt <= r_drain_cnt + c_DCNT_ONE;
          end
        end
        default: begin
          r_state  <= S_HALTED;
          r_pcd    <= '0;
          r_instrd <= NOP_INSTR;
          r_validd <= 1'b0;
          r_halted <= 1'b1;
        end
      endcase
    end
  end

  assign bus.instruction_mem_addr_o = r_pc;
  assign bus.PCD_o                  = r_pcd;
  assign bus.instrD_o               = r_instrd;
  assign bus.validD_o               = r_validd;
  assign bus.halted_o               = r_halted;
  assign bus.fetch_count_o          = r_fetch_count;

endmodule
`default_nettype wire

// File: tb/tb_if_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_if_stage                                                     |
// | Desc     : Directed self-checking bench for if_stage.                      |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module tb_if_stage;

  logic clk;
  logic rst;
  int   passed;
  int   total;

  if_stage_if #(.DATA_WIDTH(16), .ADDR_WIDTH(8), .CNT_WIDTH(16)) bus ();

  if_stage #(
    .DATA_WIDTH  (16),
    .ADDR_WIDTH  (8),
    .RESET_PC    (8'h00),
    .NOP_INSTR   (16'h0000),
    .DRAIN_CYCLES(3),
    .CNT_WIDTH   (16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Instruction memory: word at address a is 16'hC0aa.
  assign bus.instruction_mem_rD_i = {8'hC0, bus.instruction_mem_addr_o};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.stall_IF_ID_i  = 1'b0;
    bus.flush_IF_ID_i  = 1'b0;
    bus.Jump_i         = 1'b0;
    bus.jumpAddr_i     = 8'h00;
    bus.PCSrcE_i       = 1'b0;
    bus.branchTarget_i = 8'h00;
    bus.Stop_i         = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b1;
    step();
    step();
    total++; if (bus.instruction_mem_addr_o !== 8'h00) $display("FAIL reset_addr got %h exp 00", bus.instruction_mem_addr_o); else passed++;
    total++; if (bus.PCD_o !== 8'h00) $display("FAIL reset_pcd got %h exp 00", bus.PCD_o); else passed++;
    total++; if (bus.instrD_o !== 16'h0000) $display("FAIL reset_instr got %h exp 0000", bus.instrD_o); else passed++;
    total++; if (bus.validD_o !== 1'b0) $display("FAIL reset_valid got %b exp 0", bus.validD_o); else passed++;
    total++; if (bus.halted_o !== 1'b0) $display("FAIL reset_halted got %b exp 0", bus.halted_o); else passed++;
    total++; if (bus.fetch_count_o !== 16'd0) $display("FAIL reset_count got %0d exp 0", bus.fetch_count_o); else passed++;
    rst = 1'b0;
  endtask

  task automatic test_sequential();
    logic [7:0] exp_pcd [3];
    exp_pcd[0] = 8'h00; exp_pcd[1] = 8'h01; exp_pcd[2] = 8'h02;
    for (int i = 0; i < 3; i++) begin
      step();
      total++; if (bus.instruction_mem_addr_o !== exp_pcd[i] + 8'h01) $display("FAIL seq_addr%0d got %h exp %h", i, bus.instruction_mem_addr_o, exp_pcd[i] + 8'h01); else passed++;
      total++; if (bus.PCD_o !== exp_pcd[i]) $display("FAIL seq_pcd%0d got %h exp %h", i, bus.PCD_o, exp_pcd[i]); else passed++;
      total++; if (bus.instrD_o !== {8'hC0, exp_pcd[i]}) $display("FAIL seq_instr%0d got %h exp %h", i, bus.instrD_o, {8'hC0, exp_pcd[i]}); else passed++;
      total++; if (bus.validD_o !== 1'b1) $display("FAIL seq_valid%0d got %b exp 1", i, bus.validD_o); else passed++;
    end
    total++; if (bus.fetch_count_o !== 16'd3) $display("FAIL seq_count got %0d exp 3", bus.fetch_count_o); else passed++;
  endtask

  task automatic test_wrap();
    bus.Jump_i = 1'b1; bus.jumpAddr_i = 8'hFF;
    step();
    bus.Jump_i = 1'b0;
    total++; if (bus.instruction_mem_addr_o !== 8'hFF) $display("FAIL wrap_jump_addr got %h exp ff", bus.instruction_mem_addr_o); else passed++;
    step();
    total++; if (bus.instruction_mem_addr_o !== 8'h00) $display("FAIL wrap_addr got %h exp 00", bus.instruction_mem_addr_o); else passed++;
    total++; if (bus.PCD_o !== 8'hFF) $display("FAIL wrap_pcd_ff got %h exp ff", bus.PCD_o); else passed++;
    total++; if (bus.instrD_o !== 16'hC0FF) $display("FAIL wrap_instr got %h exp c0ff", bus.instrD_o); else passed++;
    step();
    total++; if (bus.PCD_o !== 8'h00) $display("FAIL wrap_pcd_00 got %h exp 00", bus.PCD_o); else passed++;
    total++; if (bus.instruction_mem_addr_o !== 8'h01) $display("FAIL wrap_addr2 got %h exp 01", bus.instruction_mem_addr_o); else passed++;
  endtask

  task automatic test_jump();
    bus.Jump_i = 1'b1; bus.jumpAddr_i = 8'h40;
    step();
    bus.Jump_i = 1'b0;
    total++; if (bus.instruction_mem_addr_o !== 8'h40) $display("FAIL jump_addr got %h exp 40", bus.instruction_mem_addr_o); else passed++;
    total++; if (bus.validD_o !== 1'b0) $display("FAIL jump_bubble got %b exp 0", bus.validD_o); else passed++;
    total++; if (bus.instrD_o !== 16'h0000) $display("FAIL jump_bubble_instr got %h exp 0000", bus.instrD_o); else passed++;
    step();
    total++; if (bus.PCD_o !== 8'h40 || bus.validD_o !== 1'b1) $display("FAIL jump_target_pcd got %h/%b exp 40/1", bus.PCD_o, bus.validD_o); else passed++;
    bus.stall_IF_ID_i = 1'b1; bus.Jump_i = 1'b1; bus.jumpAddr_i = 8'h80;
    step();
    clear_inputs();
    total++; if (bus.instruction_mem_addr_o !== 8'h41) $display("FAIL stall_jump_addr got %h exp 41", bus.instruction_mem_addr_o); else passed++;
    total++; if (bus.PCD_o !== 8'h40 || bus.validD_o !== 1'b1) $display("FAIL stall_hold got %h/%b exp 40/1", bus.PCD_o, bus.validD_o); else passed++;
    total++; if (bus.fetch_count_o !== 16'd6) $display("FAIL stall_count got %0d exp 6", bus.fetch_count_o); else passed++;
  endtask

  task automatic test_branch_priority();
    bus.PCSrcE_i = 1'b1; bus.branchTarget_i = 8'h10;
    bus.Jump_i = 1'b1; bus.jumpAddr_i = 8'h20; bus.stall_IF_ID_i = 1'b1;
    step();
    clear_inputs();
    total++; if (bus.instruction_mem_addr_o !== 8'h10) $display("FAIL branch_addr got %h exp 10", bus.instruction_mem_addr_o); else passed++;
    total++; if (bus.validD_o !== 1'b0 || bus.PCD_o !== 8'h00) $display("FAIL branch_bubble got %b/%h exp 0/00", bus.validD_o, bus.PCD_o); else passed++;
    bus.flush_IF_ID_i = 1'b1;
    step();
    bus.flush_IF_ID_i = 1'b0;
    total++; if (bus.instruction_mem_addr_o !== 8'h11 || bus.validD_o !== 1'b0) $display("FAIL flush got %h/%b exp 11/0", bus.instruction_mem_addr_o, bus.validD_o); else passed++;
    step();
    total++; if (bus.PCD_o !== 8'h11 || bus.fetch_count_o !== 16'd7) $display("FAIL post_flush got %h/%0d exp 11/7", bus.PCD_o, bus.fetch_count_o); else passed++;
  endtask

  task automatic test_stop_halt();
    bus.Stop_i = 1'b1;
    step();
    bus.Stop_i = 1'b0;
    total++; if (bus.instruction_mem_addr_o !== 8'h12 || bus.validD_o !== 1'b0) $display("FAIL stop_accept got %h/%b exp 12/0", bus.instruction_mem_addr_o, bus.validD_o); else passed++;
    bus.Jump_i = 1'b1; bus.jumpAddr_i = 8'h33; bus.PCSrcE_i = 1'b1; bus.branchTarget_i = 8'h55;
    step();
    step();
    total++; if (bus.halted_o !== 1'b0) $display("FAIL halt_early got %b exp 0", bus.halted_o); else passed++;
    step();
    total++; if (bus.halted_o !== 1'b1) $display("FAIL halt_edge4 got %b exp 1", bus.halted_o); else passed++;
    total++; if (bus.instruction_mem_addr_o !== 8'h12) $display("FAIL halt_pc got %h exp 12", bus.instruction_mem_addr_o); else passed++;
    step();
    step();
    total++; if (bus.instruction_mem_addr_o !== 8'h12 || bus.halted_o !== 1'b1 || bus.validD_o !== 1'b0) $display("FAIL halted_frozen got %h/%b/%b exp 12/1/0", bus.instruction_mem_addr_o, bus.halted_o, bus.validD_o); else passed++;
    total++; if (bus.fetch_count_o !== 16'd7) $display("FAIL halted_count got %0d exp 7", bus.fetch_count_o); else passed++;
    clear_inputs();
    rst = 1'b1;
    step();
    rst = 1'b0;
    total++; if (bus.instruction_mem_addr_o !== 8'h00 || bus.halted_o !== 1'b0) $display("FAIL halt_reset got %h/%b exp 00/0", bus.instruction_mem_addr_o, bus.halted_o); else passed++;
  endtask

  task automatic test_reset_in_drain();
    step();
    step();
    bus.Stop_i = 1'b1;
    step();
    bus.Stop_i = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    total++; if (bus.instruction_mem_addr_o !== 8'h00 || bus.validD_o !== 1'b0 || bus.fetch_count_o !== 16'd0) $display("FAIL drain_reset got %h/%b/%0d exp 00/0/0", bus.instruction_mem_addr_o, bus.validD_o, bus.fetch_count_o); else passed++;
    step();
    total++; if (bus.instruction_mem_addr_o !== 8'h01 || bus.PCD_o !== 8'h00 || bus.validD_o !== 1'b1) $display("FAIL drain_resume got %h/%h/%b exp 01/00/1", bus.instruction_mem_addr_o, bus.PCD_o, bus.validD_o); else passed++;
    for (int i = 0; i < 4; i++) step();
    total++; if (bus.halted_o !== 1'b0 || bus.fetch_count_o !== 16'd5) $display("FAIL drain_no_halt got %b/%0d exp 0/5", bus.halted_o, bus.fetch_count_o); else passed++;
  endtask

  initial begin
    passed = 0;
    total  = 0;
    rst    = 1'b1;
    clear_inputs();
    test_reset();
    test_sequential();
    test_wrap();
    test_jump();
    test_branch_priority();
    test_stop_halt();
    test_reset_in_drain();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
